// File: rtl/wb_ram_slave.sv
// Wishbone B4 pipelined slave driving a single-port synchronous RAM.
// Reads and full-word writes map to one RAM access; partial writes become a read-modify-write.
module wb_ram_slave #(
  parameter int ADR_WIDTH = 16,
  parameter int DAT_WIDTH = 16,
  localparam int SEL_WIDTH = DAT_WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [ADR_WIDTH-1:0] wb_adr_i,
  input  logic [SEL_WIDTH-1:0] wb_sel_i,
  input  logic [DAT_WIDTH-1:0] wb_dat_i,
  output logic [DAT_WIDTH-1:0] wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_stall_o,
  output logic [ADR_WIDTH-1:0] ram_a,
  output logic [DAT_WIDTH-1:0] ram_d,
  input  logic [DAT_WIDTH-1:0] ram_q,
  output logic                 ram_cen,
  output logic                 ram_wen
);

  typedef enum logic {IDLE = 1'b0, RMW = 1'b1} state_t;

  state_t                 state_reg, state_next;
  logic                   ack_reg, ack_next;
  logic [ADR_WIDTH-1:0]   adr_reg;
  logic [DAT_WIDTH-1:0]   dat_reg;
  logic [SEL_WIDTH-1:0]   sel_reg;
  logic [DAT_WIDTH-1:0]   merge_d;
  logic                   accept;
  logic                   sel_full;
  logic                   sel_none;
  logic                   partial_wr;

  assign accept     = wb_cyc_i & wb_stb_i & (state_reg == IDLE) & ~reset;
  assign sel_full   = &wb_sel_i;
  assign sel_none   = ~|wb_sel_i;
  assign partial_wr = wb_we_i & ~sel_full & ~sel_none;

  assign wb_stall_o = (state_reg == RMW);
  assign wb_dat_o   = ram_q;
  // Gating with cyc hides an ack that was pending when the master abandoned the cycle
  assign wb_ack_o   = ack_reg & wb_cyc_i;

  // Per-lane merge of latched write data over the old word read back from RAM
  generate
    for (genvar gi = 0; gi < SEL_WIDTH; gi++) begin : g_lane
      assign merge_d[8*gi +: 8] = sel_reg[gi] ? dat_reg[8*gi +: 8] : ram_q[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && partial_wr) state_next = RMW;
      RMW:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ram_cen = 1'b0;
    ram_wen = 1'b0;
    ram_a   = wb_adr_i;
    ram_d   = wb_dat_i;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          ram_cen = ~(wb_we_i & sel_none);
          ram_wen = wb_we_i & sel_full;
        end
      end
      RMW: begin
        // The merge write completes even if cyc drops; only reset suppresses it
        ram_cen = ~reset;
        ram_wen = 1'b1;
        ram_a   = adr_reg;
        ram_d   = merge_d;
      end
      default: ;
    endcase
  end

  always_comb begin
    ack_next = 1'b0;
    if (state_reg == IDLE) begin
      ack_next = accept & ~partial_wr;
    end else begin
      ack_next = wb_cyc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_reg <= 1'b0;
    end else begin
      ack_reg <= ack_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      adr_reg <= wb_adr_i;
      dat_reg <= wb_dat_i;
      sel_reg <= wb_sel_i;
    end
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave with a behavioural 64Kx16 single-port RAM.
module tb_wb_ram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [15:0] wb_adr_i;
  logic [1:0]  wb_sel_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_ack_o, wb_stall_o;
  logic [15:0] ram_a, ram_d, ram_q;
  logic        ram_cen, ram_wen;

  logic [15:0] mem [0:65535];
  int n_asserts = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_ram_slave #(.ADR_WIDTH(16), .DAT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o),
    .ram_a(ram_a), .ram_d(ram_d), .ram_q(ram_q),
    .ram_cen(ram_cen), .ram_wen(ram_wen)
  );

  // One-cycle-latency synchronous RAM
  always @(posedge clk) begin
    if (ram_cen) begin
      if (ram_wen) mem[ram_a] <= ram_d;
      else         ram_q <= mem[ram_a];
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cyc, input logic stb, input logic we,
                       input logic [15:0] adr, input logic [1:0] sel, input logic [15:0] dat);
    wb_cyc_i = cyc; wb_stb_i = stb; wb_we_i = we;
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 16'h0, 2'b00, 16'h0);
    mem[16'h0010] = 16'h1122;
    mem[16'h0020] = 16'h1122;
    mem[16'h0030] = 16'h5555;
    mem[16'h0040] = 16'hABCD;
    mem[16'h0050] = 16'h0F0F;
    for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
    tick(); tick();
    chk("reset_ack", {15'd0, wb_ack_o}, 16'd0);
    chk("reset_stall", {15'd0, wb_stall_o}, 16'd0);
    chk("reset_cen", {15'd0, ram_cen}, 16'd0);
    reset = 1'b0;
    $display("reset released");

    // Full write then read-after-write
    drive(1, 1, 1, 16'h1234, 2'b11, 16'hA5C3);
    chk("fw_cen", {15'd0, ram_cen}, 16'd1);
    chk("fw_wen", {15'd0, ram_wen}, 16'd1);
    chk("fw_d", ram_d, 16'hA5C3);
    tick();
    chk("fw_ack", {15'd0, wb_ack_o}, 16'd1);
    drive(1, 1, 0, 16'h1234, 2'b11, 16'h0);
    chk("rd_wen", {15'd0, ram_wen}, 16'd0);
    tick();
    drive(1, 0, 0, 16'h0, 2'b00, 16'h0);
    chk("rd_ack", {15'd0, wb_ack_o}, 16'd1);
    chk("rd_dat", wb_dat_o, 16'hA5C3);
    chk("rd_stall", {15'd0, wb_stall_o}, 16'd0);
    $display("full write 1234=A5C3 then read: dat=%h", wb_dat_o);
    tick();
    chk("idle_ack", {15'd0, wb_ack_o}, 16'd0);

    // Partial write sel=01 on 0x1122
    drive(1, 1, 1, 16'h0010, 2'b01, 16'hFFEE);
    chk("pw01_rd_cen", {15'd0, ram_cen}, 16'd1);
    chk("pw01_rd_wen", {15'd0, ram_wen}, 16'd0);
    tick();
    drive(1, 0, 0, 16'h0, 2'b00, 16'h0);
    chk("pw01_stall", {15'd0, wb_stall_o}, 16'd1);
    chk("pw01_wen", {15'd0, ram_wen}, 16'd1);
    chk("pw01_a", ram_a, 16'h0010);
    chk("pw01_d", ram_d, 16'h11EE);
    chk("pw01_noack", {15'd0, wb_ack_o}, 16'd0);
    tick();
    chk("pw01_ack", {15'd0, wb_ack_o}, 16'd1);
    chk("pw01_stall_off", {15'd0, wb_stall_o}, 16'd0);
    drive(1, 1, 0, 16'h0010, 2'b00, 16'h0);
    tick();
    drive(1, 0, 0, 16'h0, 2'b00, 16'h0);
    chk("pw01_rd", wb_dat_o, 16'h11EE);
    $display("partial write sel=01 at 0010: readback=%h", wb_dat_o);

    // Partial write sel=10 on 0x1122
    drive(1, 1, 1, 16'h0020, 2'b10, 16'hFFEE);
    tick();
    drive(1, 0, 0, 16'h0, 2'b00, 16'h0);
    chk("pw10_d", ram_d, 16'hFF22);
    tick();
    chk("pw10_ack", {15'd0, wb_ack_o}, 16'd1);
    chk("pw10_mem", mem[16'h0020], 16'hFF22);
    $display("partial write sel=10 at 0020: mem=%h", mem[16'h0020]);

    // Null write
    drive(1, 1, 1, 16'h0030, 2'b00, 16'hFFFF);
    chk("null_cen", {15'd0, ram_cen}, 16'd0);
    tick();
    drive(1, 0, 0, 16'h0, 2'b00, 16'h0);
    chk("null_ack", {15'd0, wb_ack_o}, 16'd1);
    chk("null_mem", mem[16'h0030], 16'h5555);
    $display("null write at 0030: mem=%h", mem[16'h0030]);
    tick();

    // Eight back-to-back reads
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 16'(i), 2'b11, 16'h0);
      chk("stream_stall", {15'd0, wb_stall_o}, 16'd0);
      tick();
      chk("stream_ack", {15'd0, wb_ack_o}, 16'd1);
      chk("stream_dat", wb_dat_o, 16'h1000 + 16'(i));
      $display("stream read %0d: dat=%h", i, wb_dat_o);
    end
    drive(1, 0, 0, 16'h0, 2'b00, 16'h0);
    tick();
    chk("stream_end", {15'd0, wb_ack_o}, 16'd0);

    // Read / partial write / read mix
    drive(1, 1, 0, 16'h0010, 2'b11, 16'h0);
    tick();
    drive(1, 1, 1, 16'h0020, 2'b01, 16'h0077);
    chk("mix_ack1", {15'd0, wb_ack_o}, 16'd1);
    chk("mix_dat1", wb_dat_o, 16'h11EE);
    tick();
    drive(1, 0, 0, 16'h0, 2'b00, 16'h0);
    chk("mix_noack", {15'd0, wb_ack_o}, 16'd0);
    chk("mix_stall", {15'd0, wb_stall_o}, 16'd1);
    tick();
    drive(1, 1, 0, 16'h0020, 2'b11, 16'h0);
    chk("mix_ack2", {15'd0, wb_ack_o}, 16'd1);
    tick();
    drive(1, 0, 0, 16'h0, 2'b00, 16'h0);
    chk("mix_ack3", {15'd0, wb_ack_o}, 16'd1);
    chk("mix_dat3", wb_dat_o, 16'hFF77);
    $display("mix: read 0010=11EE, rmw 0020, read 0020=%h", wb_dat_o);
    tick();

    // Drop cyc after an accepted read
    drive(1, 1, 0, 16'h0001, 2'b11, 16'h0);
    tick();
    drive(0, 0, 0, 16'h0, 2'b00, 16'h0);
    chk("cyc_drop_rd", {15'd0, wb_ack_o}, 16'd0);
    tick();
    chk("cyc_drop_rd2", {15'd0, wb_ack_o}, 16'd0);
    $display("cyc dropped after read: ack=%b", wb_ack_o);

    // Drop cyc during RMW
    drive(1, 1, 1, 16'h0040, 2'b10, 16'h1234);
    tick();
    drive(0, 0, 0, 16'h0, 2'b00, 16'h0);
    chk("cyc_rmw_cen", {15'd0, ram_cen}, 16'd1);
    chk("cyc_rmw_d", ram_d, 16'h12CD);
    tick();
    drive(1, 0, 0, 16'h0, 2'b00, 16'h0);
    chk("cyc_rmw_noack", {15'd0, wb_ack_o}, 16'd0);
    chk("cyc_rmw_mem", mem[16'h0040], 16'h12CD);
    $display("cyc dropped during rmw: mem 0040=%h", mem[16'h0040]);
    tick();

    // Reset during RMW
    drive(1, 1, 1, 16'h0050, 2'b01, 16'h00AA);
    tick();
    reset = 1'b1;
    drive(1, 0, 0, 16'h0, 2'b00, 16'h0);
    chk("rst_rmw_cen", {15'd0, ram_cen}, 16'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_rmw_ack", {15'd0, wb_ack_o}, 16'd0);
    chk("rst_rmw_stall", {15'd0, wb_stall_o}, 16'd0);
    chk("rst_rmw_cen2", {15'd0, ram_cen}, 16'd0);
    chk("rst_rmw_mem", mem[16'h0050], 16'h0F0F);
    $display("reset during rmw: mem 0050=%h", mem[16'h0050]);
    tick();
    chk("rst_rmw_ack2", {15'd0, wb_ack_o}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_ram_slave.md
# wb_ram_slave

Wishbone B4 pipelined slave that acts as the initiator on the single-port synchronous RAM interface (a/d/q/cen/wen, one-cycle read latency, no byte enables). It accepts one Wishbone request per cycle and converts reads and full-word writes directly into RAM accesses. Partial-byte writes become a two-cycle read-modify-write. It sits between the system interconnect and the 64 K×16 RAM macro.

## Interface
- ADR_WIDTH, 16, word address width; the RAM holds 2**ADR_WIDTH words.
- DAT_WIDTH, 16, data width; must be a multiple of 8. SEL_WIDTH = DAT_WIDTH/8.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  request strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  ADR_WIDTH  word address.
- wb_sel_i  in  SEL_WIDTH  byte lane select; bit i covers bits 8i+7:8i.
- wb_dat_i  in  DAT_WIDTH  write data.
- wb_dat_o  out  DAT_WIDTH  read data; valid only while wb_ack_o = 1 for a read.
- wb_ack_o  out  1  one-cycle acknowledge per accepted request.
- wb_stall_o  out  1  request not accepted this cycle.
- ram_a  out  ADR_WIDTH  RAM address.
- ram_d  out  DAT_WIDTH  RAM write data.
- ram_q  in  DAT_WIDTH  RAM read data; valid the cycle after ram_cen = 1.
- ram_cen  out  1  RAM access enable, active-high.
- ram_wen  out  1  RAM write enable, active-high; qualified by ram_cen.

## Operation
- Accept condition: wb_cyc_i & wb_stb_i & !wb_stall_o & !reset.
- FSM states:
  - IDLE: wb_stall_o = 0; RAM ports driven combinationally from the Wishbone inputs.
  - RMW: wb_stall_o = 1.
- Accepted read: ram_cen = 1, ram_wen = 0, ram_a = wb_adr_i. wb_sel_i is ignored and the full word is returned.
- Accepted write, all sel bits set: ram_cen = 1, ram_wen = 1, ram_d = wb_dat_i.
- Accepted write, sel = 0: no RAM access (ram_cen = 0). The request is still acknowledged.
- Accepted write, partial sel:
  - Accept cycle: issue a RAM read of wb_adr_i. Latch adr, dat and sel. Go to RMW.
  - RMW cycle: ram_cen = 1, ram_wen = 1, ram_a = latched adr. For each lane, ram_d takes the latched dat where sel = 1 and ram_q where sel = 0. Return to IDLE.
- Ack:
  - A registered ack pipeline delivers exactly one ack per accepted request, in acceptance order.
  - wb_dat_o = ram_q whenever wb_ack_o = 1.
- wb_cyc_i deassertion:
  - Clears any pending ack; no ack appears after wb_cyc_i has been low.
  - An in-progress RMW write cycle still completes to the RAM, so memory is never left half-updated.
- Outside an accept or RMW cycle: ram_cen = 0. ram_a, ram_d and ram_wen are don't-care when ram_cen = 0.

## Timing
- Reset values: state IDLE, wb_ack_o = 0, wb_stall_o = 0, ram_cen = 0. wb_dat_o is don't-care while ack = 0.
- Read, full write, null write: accepted at cycle T, ack at T+1, throughput one per cycle with no bubbles.
- Partial write: accepted at T, wb_stall_o = 1 during T+1 (RAM write cycle), ack at T+2. The next request can be accepted at T+2.
- Read-after-write to the same address:
  - After a full write accepted at T, a read accepted at T+1 returns the new data at T+2.
  - After an RMW accepted at T, a read accepted at T+2 returns the merged data.
- Reset asserted mid-RMW: the RAM write in that cycle is suppressed (ram_cen = 0), state returns to IDLE, and the pending ack is dropped.
- wb_stb_i while wb_cyc_i = 0: ignored.
- Back-to-back partial writes: one accept every 2 cycles.

## Test plan
- Reset, then a full write of 0xA5C3 to 0x1234 at T followed by a read of 0x1234 at T+1 -> acks at T+1 and T+2; wb_dat_o = 0xA5C3 at T+2; wb_stall_o stays 0.
- Memory 0x0010 = 0x1122; write sel = 01, dat 0xFFEE at T -> stall at T+1, RAM write of 0x11EE at T+1, ack at T+2; a following read returns 0x11EE.
- Same with sel = 10, dat 0xFFEE on 0x1122 -> memory = 0xFF22. A write with sel = 00 -> ack at T+1, ram_cen never asserted, memory unchanged.
- Streams:
  - 8 back-to-back reads of 0x0000-0x0007 -> 8 consecutive acks with the correct data.
  - A read / partial-write / read mix -> ack count equals accept count and acks arrive in order.
- Drop wb_cyc_i the cycle after a read is accepted -> no ack is issued. Drop wb_cyc_i during the RMW cycle -> the RAM write still occurs and no ack is issued.
- Assert reset during the RMW cycle -> no RAM write and no ack; the outputs return to their reset values on the next cycle.
